// File: rtl/calc_pkg.sv
// Shared key codes, ALU operation encodings, sequencer states and key-decode helpers
// for the calculator sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NUM1   = 3'd1,
        ST_OP     = 3'd2,
        ST_NUM2   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_RESULT = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_oper(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_ADD: op = ALU_ADD;
            KEY_SUB: op = ALU_SUB;
            KEY_MUL: op = ALU_MUL;
            KEY_DIV: op = ALU_DIV;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand register: clear, load or accumulate (val*10+digit), with a
// combinational flag telling the controller the next digit would not fit.
module calc_digit_acc #(
    parameter int OPW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           load,
    input  logic           acc,
    input  logic [3:0]     digit,
    input  logic [OPW-1:0] load_val,
    output logic [OPW-1:0] val,
    output logic [OPW-1:0] val_nx,
    output logic           ovf
);

    logic [OPW-1:0] val_r;
    logic [OPW+3:0] acc_s;

    // Four extra bits always hold (2**OPW-1)*10+15, so the wide sum never wraps.
    assign acc_s = {4'b0000, val_r} * (OPW+4)'(4'd10) + (OPW+4)'(digit);
    assign ovf   = (acc_s[OPW+3:OPW] != 4'b0000);
    assign val   = val_r;

    // Next operand value; clear beats load beats accumulate.
    always_comb begin
        val_nx = val_r;
        if (clr) begin
            val_nx = {OPW{1'b0}};
        end else if (load) begin
            val_nx = load_val;
        end else if (acc) begin
            val_nx = acc_s[OPW-1:0];
        end else begin
            val_nx = val_r;
        end
    end

    // Operand register.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_r <= {OPW{1'b0}};
        end else begin
            val_r <= val_nx;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad-driven calculator sequencer: builds two operands and an operator, launches the ALU
// and drives the display. Define CALC_CHAIN_EN to let an operator after a result chain it.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int OPW     = 8,
    parameter int RESW    = 16,
    parameter int ALU_TMO = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_en,
    input  logic [3:0]      key_code,
    output logic            alu_start,
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    output logic [1:0]      alu_op,
    input  logic            alu_done,
    input  logic [RESW-1:0] alu_result,
    input  logic            alu_err,
    output logic [RESW-1:0] disp_val,
    output logic            disp_err,
    output logic            busy
);

    localparam int TW = $clog2(ALU_TMO + 1);

    state_t          state_r, state_nx;
    logic [1:0]      op_r, op_nx;
    logic [TW-1:0]   tmo_r, tmo_nx;
    logic            start_r, start_nx;
    logic [RESW-1:0] disp_r, disp_nx;
    logic            err_r, busy_r;

    logic            dig_s, opr_s, eq_s, clr_s;
    logic [OPW-1:0]  digit_s;
    logic            n1_clr_s, n1_load_s, n1_acc_s, n1_ovf_s;
    logic            n2_clr_s, n2_load_s, n2_acc_s, n2_ovf_s;
    logic [OPW-1:0]  n1_load_val_s, n1_val_s, n1_nx_s, n2_val_s, n2_nx_s;

    assign dig_s   = key_en & is_digit(key_code);
    assign opr_s   = key_en & is_oper(key_code);
    assign eq_s    = key_en & (key_code == KEY_EQ);
    assign clr_s   = key_en & (key_code == KEY_CLR);
    assign digit_s = OPW'(key_code);

    calc_digit_acc #(.OPW(OPW)) u_num1 (
        .clk(clk), .rst(rst), .clr(n1_clr_s), .load(n1_load_s), .acc(n1_acc_s),
        .digit(key_code), .load_val(n1_load_val_s), .val(n1_val_s), .val_nx(n1_nx_s),
        .ovf(n1_ovf_s)
    );

    calc_digit_acc #(.OPW(OPW)) u_num2 (
        .clk(clk), .rst(rst), .clr(n2_clr_s), .load(n2_load_s), .acc(n2_acc_s),
        .digit(key_code), .load_val(digit_s), .val(n2_val_s), .val_nx(n2_nx_s),
        .ovf(n2_ovf_s)
    );

    // Next state, operator, operand controls, launch pulse and timeout count.
    always_comb begin
        state_nx      = state_r;
        op_nx         = op_r;
        tmo_nx        = tmo_r;
        start_nx      = 1'b0;
        n1_clr_s      = 1'b0;
        n1_load_s     = 1'b0;
        n1_acc_s      = 1'b0;
        n1_load_val_s = digit_s;
        n2_clr_s      = 1'b0;
        n2_load_s     = 1'b0;
        n2_acc_s      = 1'b0;
        if (clr_s) begin
            state_nx = ST_IDLE;
            op_nx    = ALU_ADD;
            n1_clr_s = 1'b1;
            n2_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dig_s) begin
                        state_nx  = ST_NUM1;
                        n1_load_s = 1'b1;
                    end else if (opr_s) begin
                        state_nx = ST_OP;
                        op_nx    = key_to_op(key_code);
                        n1_clr_s = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_NUM1: begin
                    if (dig_s) begin
                        n1_acc_s = ~n1_ovf_s;
                    end else if (opr_s) begin
                        state_nx = ST_OP;
                        op_nx    = key_to_op(key_code);
                    end else begin
                        state_nx = ST_NUM1;
                    end
                end
                ST_OP: begin
                    if (dig_s) begin
                        state_nx  = ST_NUM2;
                        n2_load_s = 1'b1;
                    end else if (opr_s) begin
                        op_nx = key_to_op(key_code);
                    end else begin
                        state_nx = ST_OP;
                    end
                end
                ST_NUM2: begin
                    if (dig_s) begin
                        n2_acc_s = ~n2_ovf_s;
                    end else if (eq_s) begin
                        state_nx = ST_EXEC;
                        start_nx = 1'b1;
                        tmo_nx   = {TW{1'b0}};
                    end else begin
                        state_nx = ST_NUM2;
                    end
                end
                ST_EXEC: begin
                    tmo_nx = tmo_r + TW'(1'b1);
                    if (alu_done) begin
                        state_nx = alu_err ? ST_ERR : ST_RESULT;
                    end else if (tmo_r == TW'(ALU_TMO - 1)) begin
                        state_nx = ST_ERR;
                    end else begin
                        state_nx = ST_EXEC;
                    end
                end
                ST_RESULT: begin
                    if (dig_s) begin
                        state_nx  = ST_NUM1;
                        n1_load_s = 1'b1;
`ifdef CALC_CHAIN_EN
                    end else if (opr_s) begin
                        // The displayed result is the latched ALU result while in RESULT.
                        if (|(disp_r >> OPW)) begin
                            state_nx = ST_ERR;
                        end else begin
                            state_nx      = ST_OP;
                            op_nx         = key_to_op(key_code);
                            n1_load_s     = 1'b1;
                            n1_load_val_s = disp_r[OPW-1:0];
                        end
`endif
                    end else begin
                        state_nx = ST_RESULT;
                    end
                end
                ST_ERR:  state_nx = ST_ERR;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Display value for the state being entered; EXEC keeps the last shown operand.
    always_comb begin
        disp_nx = disp_r;
        case (state_nx)
            ST_IDLE, ST_NUM1, ST_OP: disp_nx = RESW'(n1_nx_s);
            ST_NUM2:                 disp_nx = RESW'(n2_nx_s);
            ST_EXEC:                 disp_nx = disp_r;
            ST_RESULT: begin
                if (state_r == ST_EXEC) begin
                    disp_nx = alu_result;
                end else begin
                    disp_nx = disp_r;
                end
            end
            ST_ERR:  disp_nx = {RESW{1'b0}};
            default: disp_nx = {RESW{1'b0}};
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= ALU_ADD;
            tmo_r   <= {TW{1'b0}};
            start_r <= 1'b0;
            disp_r  <= {RESW{1'b0}};
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            op_r    <= op_nx;
            tmo_r   <= tmo_nx;
            start_r <= start_nx;
            disp_r  <= disp_nx;
            err_r   <= (state_nx == ST_ERR);
            busy_r  <= (state_nx == ST_EXEC);
        end
    end

    assign alu_start = start_r;
    assign alu_a     = n1_val_s;
    assign alu_b     = n2_val_s;
    assign alu_op    = op_r;
    assign disp_val  = disp_r;
    assign disp_err  = err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: a key-level calculator model checked every cycle,
// plus hand-computed expectations per scenario. Honours CALC_CHAIN_EN like the design.
module tb_calc_seq_ctrl;

    localparam int TMO = 16;
    localparam int MAXV = 255;
    localparam int M_IDLE = 0, M_NUM1 = 1, M_OP = 2, M_NUM2 = 3, M_EXEC = 4, M_RES = 5, M_ERR = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_en = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        alu_start;
    logic [7:0]  alu_a, alu_b;
    logic [1:0]  alu_op;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic        alu_err = 1'b0;
    logic [15:0] disp_val;
    logic        disp_err;
    logic        busy;

    calc_seq_ctrl #(.OPW(8), .RESW(16), .ALU_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .key_en(key_en), .key_code(key_code),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .disp_val(disp_val), .disp_err(disp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;
    int cyc = 0;
    int start_cnt = 0, start_cyc = 0, cap_a = 0, cap_b = 0, cap_op = 0;
    bit err_seen = 1'b0;
    int err_cyc = 0;

    int m_mode = M_IDLE, m_n1 = 0, m_n2 = 0, m_op = 0, m_res = 0, m_age = 0;
    int e_disp = 0, e_err = 0, e_busy = 0, e_start = 0;
    int k;
    bit kdig, kopr;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Key-level behaviour of the calculator, one step per clock edge.
    always @(posedge clk) begin
        k = int'(key_code);
        kdig = key_en && (k <= 9);
        kopr = key_en && (k >= 10) && (k <= 13);
        e_start = 0;
        if (rst) begin
            m_mode = M_IDLE; m_n1 = 0; m_n2 = 0; m_op = 0; e_disp = 0;
        end else if (key_en && k == 15) begin
            m_mode = M_IDLE; m_n1 = 0; m_n2 = 0; m_op = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (kdig) begin m_mode = M_NUM1; m_n1 = k; end
                        else if (kopr) begin m_mode = M_OP; m_n1 = 0; m_op = k - 10; end
                M_NUM1: if (kdig) begin if (m_n1 * 10 + k <= MAXV) m_n1 = m_n1 * 10 + k; end
                        else if (kopr) begin m_mode = M_OP; m_op = k - 10; end
                M_OP:   if (kdig) begin m_mode = M_NUM2; m_n2 = k; end
                        else if (kopr) m_op = k - 10;
                M_NUM2: if (kdig) begin if (m_n2 * 10 + k <= MAXV) m_n2 = m_n2 * 10 + k; end
                        else if (key_en && k == 14) begin m_mode = M_EXEC; e_start = 1; m_age = 0; end
                M_EXEC: if (alu_done) begin
                            if (alu_err) m_mode = M_ERR;
                            else begin m_mode = M_RES; m_res = int'(alu_result); end
                        end else begin
                            m_age++;
                            if (m_age == TMO) m_mode = M_ERR;
                        end
                M_RES:  if (kdig) begin m_mode = M_NUM1; m_n1 = k; end
`ifdef CALC_CHAIN_EN
                        else if (kopr) begin
                            if (m_res > MAXV) m_mode = M_ERR;
                            else begin m_mode = M_OP; m_n1 = m_res; m_op = k - 10; end
                        end
`endif
                default: ;
            endcase
        end
        case (m_mode)
            M_IDLE, M_NUM1, M_OP: e_disp = m_n1;
            M_NUM2: e_disp = m_n2;
            M_RES:  e_disp = m_res;
            M_ERR:  e_disp = 0;
            default: ;
        endcase
        e_err  = (m_mode == M_ERR) ? 1 : 0;
        e_busy = (m_mode == M_EXEC) ? 1 : 0;
    end

    always @(posedge clk) cyc++;

    // Every-cycle comparison against the model, plus launch/error bookkeeping.
    always @(negedge clk) begin
        if (checking) begin
            chk("disp_val", int'(disp_val), e_disp);
            chk("disp_err", int'(disp_err), e_err);
            chk("busy", int'(busy), e_busy);
            chk("alu_start", int'(alu_start), e_start);
            if (e_busy != 0) begin
                chk("alu_a", int'(alu_a), m_n1);
                chk("alu_b", int'(alu_b), m_n2);
                chk("alu_op", int'(alu_op), m_op);
            end
            if (alu_start) begin
                start_cnt++; start_cyc = cyc;
                cap_a = int'(alu_a); cap_b = int'(alu_b); cap_op = int'(alu_op);
            end
            if (disp_err && !err_seen) begin
                err_seen = 1'b1; err_cyc = cyc;
            end
        end
    end

    task automatic drive(input bit ken, input logic [3:0] kc, input bit dn, input bit er,
                         input logic [15:0] res);
        key_en = ken; key_code = kc; alu_done = dn; alu_err = er; alu_result = res;
        @(posedge clk); #1;
        key_en = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
    endtask

    task automatic key(input logic [3:0] kc);
        drive(1'b1, kc, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    endtask

    int sc;

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        checking = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_disp", int'(disp_val), 0);
        chk("rst_flags", int'({alu_start, disp_err, busy}), 0);
        chk("rst_ops", int'({alu_a, alu_b, alu_op}), 0);

        // 12 + 3 = 15
        start_cnt = 0;
        key(4'd1); key(4'd2); key(4'hA); key(4'd3); key(4'hE);
        idle(2);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 16'd15);
        idle(1);
        chk("t1_disp", int'(disp_val), 15);
        chk("t1_busy", int'(busy), 0);
        chk("t1_starts", start_cnt, 1);
        chk("t1_a", cap_a, 12); chk("t1_b", cap_b, 3); chk("t1_op", cap_op, 0);

        // 2559 -> 255 (9 dropped), then 255 * 2
        key(4'hF);
        key(4'd2); key(4'd5); key(4'd5); key(4'd9);
        chk("t2_drop", int'(disp_val), 255);
        key(4'hC); key(4'd2); key(4'hE);
        idle(1);
        chk("t2_a", cap_a, 255); chk("t2_b", cap_b, 2); chk("t2_op", cap_op, 2);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 16'd510);
        idle(1);
        chk("t2_res", int'(disp_val), 510);
        key(4'hA);
`ifdef CALC_CHAIN_EN
        chk("t2_chain_ovf", int'(disp_err), 1);
`else
        chk("t2_nochain", int'(disp_val), 510);
`endif

        // 9 / 0 -> ALU error
        key(4'hF);
        key(4'd9); key(4'hD); key(4'd0); key(4'hE);
        idle(1);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 16'd0);
        chk("t3_err", int'(disp_err), 1);
        key(4'd5); key(4'd3);
        chk("t3_hold_err", int'({disp_err, disp_val}), 32'h1_0000);
        key(4'hF);
        chk("t3_clr", int'({disp_err, disp_val}), 0);

        // 4 - 1 with no completion -> timeout
        err_seen = 1'b0;
        key(4'd4); key(4'hB); key(4'd1); key(4'hE);
        idle(TMO + 2);
        chk("t4_err", int'(err_seen), 1);
        chk("t4_latency", err_cyc - start_cyc, TMO);
        key(4'hF);

        // clear wins over a simultaneous completion; late completion ignored
        key(4'd1); key(4'hA); key(4'd2); key(4'hE);
        idle(2);
        drive(1'b1, 4'hF, 1'b1, 1'b0, 16'd99);
        chk("t5_clr_disp", int'(disp_val), 0);
        chk("t5_clr_busy", int'(busy), 0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 16'd77);
        chk("t5_late_done", int'(disp_val), 0);
        // non-clear key coincident with completion is dropped
        key(4'd6); key(4'hA); key(4'd7); key(4'hE);
        idle(1);
        drive(1'b1, 4'd5, 1'b1, 1'b0, 16'd13);
        idle(1);
        chk("t5_key_drop", int'(disp_val), 13);
        // reset in the middle of the second operand
        key(4'd3); key(4'hA); key(4'd4);
        chk("t5_num2", int'(disp_val), 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_rst_all", int'({alu_start, disp_err, busy, disp_val, alu_a, alu_b, alu_op}), 0);

        // result 15, then + 1 =
        key(4'd1); key(4'd2); key(4'hA); key(4'd3); key(4'hE);
        idle(2);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 16'd15);
        idle(1);
        sc = start_cnt;
        key(4'hA); key(4'd1); key(4'hE);
        idle(1);
`ifdef CALC_CHAIN_EN
        chk("t6_starts", start_cnt, sc + 1);
        chk("t6_a", cap_a, 15); chk("t6_b", cap_b, 1); chk("t6_op", cap_op, 0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 16'd16);
        idle(1);
        chk("t6_res", int'(disp_val), 16);
`else
        chk("t6_starts", start_cnt, sc);
        chk("t6_disp", int'(disp_val), 1);
        chk("t6_busy", int'(busy), 0);
`endif
        key(4'hF);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
